// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the RISC-V core front end.
//   XLEN       : architectural register / instruction word width
//   PC_W       : program-counter and instruction-memory byte-address width
//   NOP_INSTR  : bubble word, addi x0,x0,0
//   OP_*       : major opcodes, kept here so the decoder can reuse them
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 16;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // Instruction addresses are word aligned; any set bit in [1:0] is a
    // misaligned target.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's control inputs, the instruction-memory bus and
// the IF/ID outputs toward the decoder.
//   master : the fetch stage (drives imem_addr and the IF/ID outputs)
//   slave  : the environment (pipeline control, memory and decoder)
// Handshake semantics: there is no valid/ready pair on the memory side; the
// memory answers imem_addr combinationally in the same cycle. Toward the
// decoder, ifid_valid marks a real instruction and stall is the decoder's
// "not ready": while stall=1 (and no redirect) the IF/ID contents are held.
// ---------------------------------------------------------------------------
interface fetch_stage_if
    import riscv_pkg::*;
#(
    parameter int PC_W  = riscv_pkg::PC_W,
    parameter int CNT_W = 32
) ();

    logic             stall;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [PC_W-1:0]  imem_addr;
    logic [XLEN-1:0]  imem_instr;
    logic [XLEN-1:0]  ifid_instr;
    logic [PC_W-1:0]  ifid_pc;
    logic             ifid_valid;
    logic             misalign;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  imem_instr,
        output imem_addr,
        output ifid_instr,
        output ifid_pc,
        output ifid_valid,
        output misalign,
        output fetch_count
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output imem_instr,
        input  imem_addr,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_valid,
        input  misalign,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// ---------------------------------------------------------------------------
// fetch_stage_ifid_reg (module ifid_reg)
// IF/ID pipeline register with flush/hold/load controls.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_flush    : insert a bubble (NOP, valid=0); pc field is kept
//   i_hold     : keep current contents
//   i_instr    : instruction to load when neither flush nor hold
//   i_pc       : PC of i_instr
//   o_instr, o_pc, o_valid : registered outputs to the decoder
// Priority: flush > hold > load.
// ---------------------------------------------------------------------------
module ifid_reg
    import riscv_pkg::*;
#(
    parameter int              PC_W      = riscv_pkg::PC_W,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_hold,
    input  logic [XLEN-1:0] i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic [XLEN-1:0] o_instr,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            // Bubble: the pc field deliberately keeps its old value.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives it as a byte address to a
// zero-latency instruction memory and captures the returned word into the
// IF/ID register. Handles decoder stalls, branch/jump redirects, flags
// misaligned redirect targets and counts delivered instructions.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_stage_if.master
//                in : stall, redirect, redirect_pc, imem_instr
//                out: imem_addr, ifid_instr, ifid_pc, ifid_valid,
//                     misalign, fetch_count
// Per edge priority: redirect > stall > advance.
// ---------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              PC_W      = riscv_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
    parameter int              CNT_W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0]  r_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_fetch_count;

    logic [PC_W-1:0]  w_pc_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_misalign_next;
    logic             w_advance;

    assign w_advance = !bus.redirect && !bus.stall;

    always_comb begin
        w_pc_next       = r_pc;
        w_count_next    = r_fetch_count;
        w_misalign_next = 1'b0;
        if (bus.redirect) begin
            // Target is forced to word alignment; the dropped bits only
            // raise the misalign pulse.
            w_pc_next       = {bus.redirect_pc[PC_W-1:2], 2'b00};
            w_misalign_next = is_misaligned(bus.redirect_pc[1:0]);
        end else if (w_advance) begin
            // Wraps modulo 2^PC_W with no flag.
            w_pc_next = r_pc + PC_W'(4);
            if (r_fetch_count != '1) begin
                w_count_next = r_fetch_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_misalign    <= w_misalign_next;
            r_fetch_count <= w_count_next;
        end
    end

    ifid_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.redirect),
        .i_hold  (bus.stall),
        .i_instr (bus.imem_instr),
        .i_pc    (r_pc),
        .o_instr (bus.ifid_instr),
        .o_pc    (bus.ifid_pc),
        .o_valid (bus.ifid_valid)
    );

    // Memory is combinational, so the address is the PC itself.
    assign bus.imem_addr   = r_pc;
    assign bus.misalign    = r_misalign;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed test of fetch_stage. A second instance with a 2-bit counter
// exercises counter saturation alongside the main instance.
// Memory image: word at byte address A is addi x1,x0,A[11:0].
// ---------------------------------------------------------------------------
module tb_fetch_stage;
    import riscv_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    fetch_stage_if #(.PC_W(16), .CNT_W(32)) bus ();
    fetch_stage_if #(.PC_W(16), .CNT_W(2))  bus2 ();

    fetch_stage #(
        .PC_W      (16),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(
        .PC_W      (16),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (2)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    assign bus.imem_instr   = mem_word(bus.imem_addr);
    assign bus2.imem_instr  = mem_word(bus2.imem_addr);
    assign bus2.stall       = bus.stall;
    assign bus2.redirect    = bus.redirect;
    assign bus2.redirect_pc = bus.redirect_pc;

    // ---------------- scoreboard counters ----------------
    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] addr,
                            input logic [31:0] instr, input logic [15:0] pc,
                            input logic valid, input logic [31:0] cnt);
        chk({tag, ".imem_addr"},   {16'h0, bus.imem_addr}, {16'h0, addr});
        chk({tag, ".ifid_instr"},  bus.ifid_instr,         instr);
        chk({tag, ".ifid_pc"},     {16'h0, bus.ifid_pc},   {16'h0, pc});
        chk({tag, ".ifid_valid"},  {31'h0, bus.ifid_valid}, {31'h0, valid});
        chk({tag, ".fetch_count"}, bus.fetch_count,        cnt);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);

        // Reset values
        #12;
        chk_ifid("reset", 16'h0000, 32'h0000_0013, 16'h0000, 1'b0, 32'd0);
        chk("reset.misalign", {31'h0, bus.misalign}, 32'h0);
        chk("reset.sat_count", {30'h0, bus2.fetch_count}, 32'd0);
        rst_n = 1'b1;

        // 1. sequential fetch 0,4
        step();
        chk_ifid("seq0", 16'h0004, 32'h0000_0093, 16'h0000, 1'b1, 32'd1);
        step();
        chk_ifid("seq1", 16'h0008, 32'h0040_0093, 16'h0004, 1'b1, 32'd2);

        // 2. stall for 3 cycles at pc=8
        drive(1'b1, 1'b0, 16'h0000);
        step();
        chk_ifid("stall0", 16'h0008, 32'h0040_0093, 16'h0004, 1'b1, 32'd2);
        step();
        step();
        chk_ifid("stall2", 16'h0008, 32'h0040_0093, 16'h0004, 1'b1, 32'd2);
        drive(1'b0, 1'b0, 16'h0000);
        step();
        chk_ifid("unstall", 16'h000C, 32'h0080_0093, 16'h0008, 1'b1, 32'd3);

        // 3. redirect to 0x40 while pc=12
        drive(1'b0, 1'b1, 16'h0040);
        step();
        chk_ifid("redir", 16'h0040, 32'h0000_0013, 16'h0008, 1'b0, 32'd3);
        chk("redir.misalign", {31'h0, bus.misalign}, 32'h0);
        drive(1'b0, 1'b0, 16'h0000);
        step();
        chk_ifid("redir_next", 16'h0044, 32'h0400_0093, 16'h0040, 1'b1, 32'd4);
        chk("sat.count", {30'h0, bus2.fetch_count}, 32'd3);

        // 4. redirect + stall together, misaligned target 0x22
        drive(1'b1, 1'b1, 16'h0022);
        step();
        chk_ifid("redir_stall", 16'h0020, 32'h0000_0013, 16'h0040, 1'b0, 32'd4);
        chk("redir_stall.misalign", {31'h0, bus.misalign}, 32'h1);
        drive(1'b0, 1'b0, 16'h0000);
        step();
        chk("misalign_pulse_end", {31'h0, bus.misalign}, 32'h0);
        chk_ifid("after_mis", 16'h0024, 32'h0200_0093, 16'h0020, 1'b1, 32'd5);

        // 5. back-to-back redirects, second lands on 0xFFFC, then wrap
        drive(1'b0, 1'b1, 16'h0100);
        step();
        chk_ifid("b2b0", 16'h0100, 32'h0000_0013, 16'h0020, 1'b0, 32'd5);
        drive(1'b0, 1'b1, 16'hFFFC);
        step();
        chk_ifid("b2b1", 16'hFFFC, 32'h0000_0013, 16'h0020, 1'b0, 32'd5);
        drive(1'b0, 1'b0, 16'h0000);
        step();
        chk_ifid("wrap", 16'h0000, 32'hFFC0_0093, 16'hFFFC, 1'b1, 32'd6);
        chk("wrap.misalign", {31'h0, bus.misalign}, 32'h0);
        step();
        chk_ifid("wrap_next", 16'h0004, 32'h0000_0093, 16'h0000, 1'b1, 32'd7);
        chk("sat.hold", {30'h0, bus2.fetch_count}, 32'd3);

        // 6. async reset mid-cycle during a stall
        drive(1'b1, 1'b0, 16'h0000);
        step();
        chk_ifid("pre_rst", 16'h0004, 32'h0000_0093, 16'h0000, 1'b1, 32'd7);
        #3;
        rst_n = 1'b0;
        #1;
        chk_ifid("async_rst", 16'h0000, 32'h0000_0013, 16'h0000, 1'b0, 32'd0);
        chk("async_rst.misalign", {31'h0, bus.misalign}, 32'h0);
        chk("async_rst.sat", {30'h0, bus2.fetch_count}, 32'd0);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        step();
        chk_ifid("post_rst", 16'h0004, 32'h0000_0093, 16'h0000, 1'b1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RISC-V core, directly upstream of the instruction memory and downstream-feeding the decoder.
- Holds the program counter and drives the PC as a byte address into the combinational instruction memory.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles decoder stalls and branch/jump redirects, and counts delivered instructions.

Parameters:
PC_W, 16, program-counter / instruction-memory address width in bits (byte address)
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/reset
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  decode/execute cannot accept; hold PC and IF/ID
redirect  input  1  branch taken or jump resolved; load redirect_pc, squash IF/ID
redirect_pc  input  PC_W  redirect target byte address
imem_addr  output  PC_W  byte address to instruction memory (= current PC)
imem_instr  input  32  instruction word returned combinationally for imem_addr
ifid_instr  output  32  registered instruction to decoder
ifid_pc  output  PC_W  PC of ifid_instr
ifid_valid  output  1  ifid_instr is a real fetched instruction
misalign  output  1  one-cycle pulse: redirect_pc[1:0] != 0 was accepted
fetch_count  output  CNT_W  number of valid instructions delivered into IF/ID

Behaviour:
Decided: one clock (clk); asynchronous, active-low reset (rst_n).

Reset (asynchronous on rst_n=0, held while low):
- pc=RESET_PC; ifid_instr=NOP_INSTR; ifid_pc=0; ifid_valid=0; misalign=0; fetch_count=0.

Memory path:
- imem_addr is a direct combinational copy of pc; no registering.
- Memory read is zero-latency, so imem_instr belongs to the current pc in the same cycle.

Per rising edge, in priority order:
1. redirect=1 (wins over stall):
   - pc <= {redirect_pc[PC_W-1:2],2'b00}.
   - IF/ID <= bubble: instr=NOP_INSTR, valid=0, ifid_pc unchanged.
   - misalign <= |redirect_pc[1:0].
   - fetch_count unchanged.
2. stall=1, redirect=0:
   - pc, ifid_* and fetch_count hold.
   - misalign <= 0.
3. Otherwise (advance):
   - ifid_instr <= imem_instr; ifid_pc <= pc; ifid_valid <= 1.
   - pc <= pc + 4.
   - fetch_count <= fetch_count + 1, saturating at all-ones.
   - misalign <= 0.

Edge rules:
- PC arithmetic is modulo 2^PC_W: 16'hFFFC + 4 -> 16'h0000, no flag.
- Latency: an instruction at address A appears on ifid_instr on the first edge where pc==A and neither stall nor redirect is asserted.
- After reset release, the first valid IF/ID entry holds the instruction at RESET_PC, one edge after release (if not stalled).
- Redirect and stall together: the redirect is taken and stall is ignored for that edge; the decoder sees a bubble.
- Back-to-back redirects: each loads a new pc and every one produces a bubble.
- Reset asserted mid-stall or mid-redirect: immediately returns to reset values; no pending state survives.
- Inputs are sampled only at clock edges; there are no combinational paths from stall/redirect to outputs.

Decomposition:
Shared package riscv_pkg holds:
- PC_W, the NOP_INSTR constant, XLEN=32
- opcode localparams (OP_IMM=7'b0010011, BRANCH, JAL, JALR) for decoder reuse

Natural sub-module: ifid_reg (IF/ID pipeline register with hold/flush/load controls). fetch_stage keeps the PC register, next-PC mux, counter and misalign logic.

Test Plan:
1. Reset release, stall=0, memory holding addi words at 0,4,8 -> imem_addr steps 0,4,8; ifid_pc 0,4,8 on successive edges; ifid_valid=1 from first edge; fetch_count 1,2,3.
2. stall=1 for 3 cycles at pc=8 -> imem_addr stays 8; ifid_instr/ifid_pc/fetch_count frozen; on release ifid_pc=8 next edge.
3. redirect=1, redirect_pc=16'h0040 while pc=12 -> next edge pc=0x40, ifid_valid=0, ifid_instr=0x00000013; following edge ifid_pc=0x40, valid=1.
4. redirect=1 and stall=1 same cycle, redirect_pc=16'h0022 -> pc=0x0020, misalign=1 for exactly one cycle, bubble in IF/ID.
5. Force pc to 16'hFFFC via redirect, then advance -> ifid_pc=0xFFFC, next pc=0x0000, no flag.
6. Assert rst_n=0 asynchronously mid-cycle during a stall -> outputs immediately at reset values without waiting for a clk edge; fetch_count=0.
